fetch_unit: RTL and testbench

Parametrised fetch stage for the RISC-V pipeline. It generalises the single-cycle F stage (PC register, +4 adder, branch/jump redirect mux) to a variable-latency instruction memory with a request/grant/response handshake. Fetched words are buffered in a DEPTH-entry instruction queue. Requests still in flight when a redirect arrives are squashed. It sits between instruction memory and the F→D pipe register and feeds decode one {instr, pc} pair per cycle.

---
 rtl/core_pkg.sv | 13 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RISC-V pipeline front end.
// Provides default widths, reset PC, the canonical NOP and PC alignment.
package core_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head and a flush that acts like reset.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & (~full | pop);
    do_pop   = pop & ~empty;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues word-aligned requests to a variable-latency imem, squashes
// responses owed to a redirected path and queues {instr, pc} pairs for decode.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
  localparam int             CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic [CW-1:0]   occupancy
);

  localparam logic [CW:0] BUDGET = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            grant, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31+XLEN:0] fifo_head;

  // Outstanding plus queued never exceeds DEPTH, so responses are never back-pressured.
  assign imem_req  = ~reset & ~redirect & ~fifo_full &
                     (({1'b0, inflight_q} + {1'b0, occupancy}) < BUDGET);
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req & imem_gnt;

  assign fifo_push = imem_rvalid & (discard_q == '0) & ~redirect;
  assign fifo_pop  = instr_valid & instr_ready & ~redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid);
    if (redirect) begin
      fetch_pc_d = pc_align(redirect_pc);
      resp_pc_d  = pc_align(redirect_pc);
      // inflight already includes words still pending discard, so this is every owed response.
      discard_d  = inflight_q - CW'(imem_rvalid);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rvalid) begin
        if (discard_q != '0) discard_d = discard_q - CW'(1);
        else                 resp_pc_d = resp_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH (32 + XLEN),
    .DEPTH (DEPTH)
  ) u_iq (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata ({imem_rdata, resp_pc_q}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy),
    .head  (fifo_head)
  );

  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_head[31+XLEN:XLEN];
  assign instr_pc    = fifo_head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order variable-latency memory model plus a
// reference built from a queue of outstanding requests tagged stale on redirect.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, redirect, imem_gnt, imem_rvalid, instr_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [2:0]  occupancy;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit stale; } out_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  out_t        out_q[$];   // requests the model believes are outstanding
  logic [31:0] mq[$];      // PCs the model believes are queued, head first
  mem_t        mem_q[$];   // memory-side pending responses
  logic [31:0] m_fetch_pc;
  int          cyc = 0, last_due = 0, lat = 1;
  int          errors = 0, checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc,
                       input bit gnt, input bit rdy, input bit chk);
    bit          rv, exp_req, dut_req;
    logic [31:0] dut_addr;
    int          due;
    @(negedge clk);
    reset       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    imem_gnt    = gnt;
    instr_ready = rdy;
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(mem_q[0].addr) : $urandom;
    #1;
    exp_req = !rst && !redir && ((out_q.size() + mq.size()) < DEPTH);
    if (chk) begin
      check("imem_req", 64'(imem_req), 64'(exp_req));
      if (exp_req) check("imem_addr", 64'(imem_addr), 64'(m_fetch_pc));
      check("instr_valid", 64'(instr_valid), 64'(mq.size() > 0));
      check("occupancy", 64'(occupancy), 64'(mq.size()));
      if (mq.size() > 0) begin
        check("instr_pc", 64'(instr_pc), 64'(mq[0]));
        check("instr", 64'(instr), 64'(mem_word(mq[0])));
      end
    end
    dut_req  = imem_req;
    dut_addr = imem_addr;
    @(posedge clk);
    // memory environment: in order, at least one cycle after grant
    if (rst) begin
      mem_q.delete();
      last_due = 0;
    end else begin
      if (rv) void'(mem_q.pop_front());
      if (dut_req && gnt) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{dut_addr, due});
      end
    end
    // reference model
    if (rst) begin
      m_fetch_pc = RST_PC;
      out_q.delete();
      mq.delete();
    end else if (redir) begin
      if (rv && out_q.size() > 0) void'(out_q.pop_front());
      foreach (out_q[i]) out_q[i].stale = 1'b1;
      mq.delete();
      m_fetch_pc = rpc & ~32'h3;
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (rv && out_q.size() > 0) begin
        if (!out_q[0].stale) mq.push_back(out_q[0].pc);
        void'(out_q.pop_front());
      end
      if (exp_req && gnt) begin
        out_q.push_back('{m_fetch_pc, 1'b0});
        m_fetch_pc += 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    m_fetch_pc = RST_PC;

    // reset, then streaming with L=1
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 1, 1);
    lat = 1;
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1, 1);

    // stall decode: fill to DEPTH, release one slot, stall again
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1, 1);

    // L=3 with requests in flight, redirect to 0x100
    lat = 3;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 1);
    cycle(0, 1, 32'h100, 1, 1, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 1, 1);

    // L=2 redirects, including misaligned target and back-to-back
    lat = 2;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 1);
    cycle(0, 1, 32'h203, 1, 1, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1, 1);
    cycle(0, 1, 32'h40, 1, 1, 1);
    cycle(0, 1, 32'h80, 1, 1, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 1, 1);

    // reset mid-operation with requests in flight and words queued
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 1);
    cycle(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1, 1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit r_rst, r_redir;
      lat     = int'($urandom_range(1, 4));
      r_rst   = ($urandom_range(0, 199) == 0);
      r_redir = !r_rst && ($urandom_range(0, 15) == 0);
      cycle(r_rst, r_redir, $urandom, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
